// File: rtl/lcd_ctrl.sv
// lcd_ctrl: queues CPU LCD register writes and replays them as HD44780 bus cycles
//   i_clk       system clock
//   i_reset     synchronous reset, active-low
//   i_wr        one-cycle write strobe from the LCD register
//   i_wdata     [31]=LCD on, [9]=RS, [7:0]=DATA
//   o_full      command queue holds FIFO_DEPTH entries
//   o_busy      queue non-empty or a bus cycle in progress
//   o_overflow  sticky, a write was dropped on a full queue
//   o_lcd_*     LCD pins (on, en, rs, rw, data)
module lcd_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int T_SETUP    = 2,
  parameter int T_EN       = 12,
  parameter int T_HOLD     = 2,
  parameter int T_EXEC     = 2000,
  parameter int T_CLEAR    = 82000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_wr,
  input  logic [31:0] i_wdata,
  output logic        o_full,
  output logic        o_busy,
  output logic        o_overflow,
  output logic        o_lcd_on,
  output logic        o_lcd_en,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic [7:0]  o_lcd_data
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(T_CLEAR + 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] C_SETUP  = CW'(T_SETUP - 1);
  localparam logic [CW-1:0] C_EN     = CW'(T_EN - 1);
  localparam logic [CW-1:0] C_HOLD   = CW'(T_HOLD - 1);
  localparam logic [CW-1:0] C_EXEC   = CW'(T_EXEC - 1);
  localparam logic [CW-1:0] C_CLEAR  = CW'(T_CLEAR - 1);
  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, WAIT} state_t;
  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [8:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push, pop, slow_cmd;
  logic          unused_wdata;
  assign unused_wdata = ^{i_wdata[30:10], i_wdata[8]};
  assign o_full   = count == FULL_CNT;
  assign o_busy   = state != IDLE || count != '0;
  assign o_lcd_en = state == PULSE;
  assign o_lcd_rw = 1'b0;
  assign push     = i_wr && !o_full;
  // clear display / return home need the long execution wait
  assign slow_cmd = !o_lcd_rs && o_lcd_data != 8'h00 && o_lcd_data[7:2] == 6'd0;
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    pop      = 1'b0;
    case (state)
      IDLE: if (count != '0) begin
        pop      = 1'b1;
        state_nx = SETUP;
        cnt_nx   = C_SETUP;
      end
      SETUP: if (cnt == '0) begin
        state_nx = PULSE;
        cnt_nx   = C_EN;
      end else cnt_nx = cnt - 1'b1;
      PULSE: if (cnt == '0) begin
        state_nx = HOLD;
        cnt_nx   = C_HOLD;
      end else cnt_nx = cnt - 1'b1;
      HOLD: if (cnt == '0) begin
        state_nx = WAIT;
        cnt_nx   = slow_cmd ? C_CLEAR : C_EXEC;
      end else cnt_nx = cnt - 1'b1;
      WAIT: if (cnt == '0) state_nx = IDLE;
        else cnt_nx = cnt - 1'b1;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state      <= IDLE;
      cnt        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      o_overflow <= 1'b0;
      o_lcd_on   <= 1'b0;
      o_lcd_rs   <= 1'b0;
      o_lcd_data <= 8'h00;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      if (push) begin
        mem[wr_ptr] <= {i_wdata[9], i_wdata[7:0]};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        {o_lcd_rs, o_lcd_data} <= mem[rd_ptr];
        rd_ptr                 <= rd_ptr + 1'b1;
      end
      if (i_wr) o_lcd_on <= i_wdata[31];
      if (i_wr && o_full) o_overflow <= 1'b1;
    end
  end
endmodule
